// File: rtl/raster_pkg.sv
// Shared types and defaults for the raster scan controller slice.
package raster_pkg;

   typedef logic signed [15:0] coord_t;
   typedef logic signed [31:0] area_t;

   typedef enum logic [1:0] {IDLE, SETUP, SCAN, DRAIN} scan_state_t;

   localparam int unsigned DEF_SCREEN_W   = 320;
   localparam int unsigned DEF_SCREEN_H   = 240;
   localparam int unsigned DEF_ENGINE_LAT = 1;

   function automatic coord_t min3(coord_t a, coord_t b, coord_t c);
      coord_t m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic coord_t max3(coord_t a, coord_t b, coord_t c);
      coord_t m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

endpackage

// File: rtl/raster_bbox.sv
// Screen-clamped bounding box of a triangle; empty when it lies fully off-screen.
module raster_bbox
   import raster_pkg::*;
#(
   parameter int unsigned SCREEN_W = DEF_SCREEN_W,
   parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
   input  coord_t i_x0,
   input  coord_t i_y0,
   input  coord_t i_x1,
   input  coord_t i_y1,
   input  coord_t i_x2,
   input  coord_t i_y2,
   output coord_t o_xmin,
   output coord_t o_xmax,
   output coord_t o_ymin,
   output coord_t o_ymax,
   output logic   o_empty
);

   localparam coord_t XLIM = coord_t'(SCREEN_W - 1);
   localparam coord_t YLIM = coord_t'(SCREEN_H - 1);

   coord_t xlo, xhi, ylo, yhi;

   always_comb begin
      xlo     = min3(i_x0, i_x1, i_x2);
      xhi     = max3(i_x0, i_x1, i_x2);
      ylo     = min3(i_y0, i_y1, i_y2);
      yhi     = max3(i_y0, i_y1, i_y2);
      o_xmin  = (xlo < 16'sd0) ? '0 : xlo;
      o_xmax  = (xhi > XLIM) ? XLIM : xhi;
      o_ymin  = (ylo < 16'sd0) ? '0 : ylo;
      o_ymax  = (yhi > YLIM) ? YLIM : yhi;
      o_empty = (o_xmin > o_xmax) || (o_ymin > o_ymax);
   end

endmodule

// File: rtl/raster_scan_ctrl.sv
// Per-triangle raster-order pixel sequencer feeding the edge engine.
// Optional back-face culling: define RASTER_BACKFACE_CULL_EN.
module raster_scan_ctrl
   import raster_pkg::*;
#(
   parameter int unsigned SCREEN_W   = DEF_SCREEN_W,
   parameter int unsigned SCREEN_H   = DEF_SCREEN_H,
   parameter int unsigned ENGINE_LAT = DEF_ENGINE_LAT
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_tri_valid,
   output logic        o_tri_ready,
   input  logic [15:0] i_x0,
   input  logic [15:0] i_y0,
   input  logic [15:0] i_x1,
   input  logic [15:0] i_y1,
   input  logic [15:0] i_x2,
   input  logic [15:0] i_y2,
   output logic [15:0] o_x0,
   output logic [15:0] o_y0,
   output logic [15:0] o_x1,
   output logic [15:0] o_y1,
   output logic [15:0] o_x2,
   output logic [15:0] o_y2,
   input  logic        i_stall,
   output logic [15:0] o_p_x,
   output logic [15:0] o_p_y,
   output logic        o_p_valid,
   output logic        o_busy,
   output logic        o_done
);

   localparam logic [15:0] DRAIN_LOAD = 16'(ENGINE_LAT - 1);

   scan_state_t state_q, state_d;
   coord_t      vx_q [3], vx_d [3];
   coord_t      vy_q [3], vy_d [3];
   coord_t      px_q, px_d, py_q, py_d;
   logic [15:0] cnt_q, cnt_d;
   logic        ready_q, ready_d, busy_q, busy_d, done_q, done_d, scan_q, scan_d;

   coord_t xmin, xmax, ymin, ymax;
   logic   bb_empty, cull, p_valid;

   // Vertices stay latched for the whole triangle, so the box is valid in SETUP and SCAN.
   raster_bbox #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
   ) u_bbox (
      .i_x0    (vx_q[0]),
      .i_y0    (vy_q[0]),
      .i_x1    (vx_q[1]),
      .i_y1    (vy_q[1]),
      .i_x2    (vx_q[2]),
      .i_y2    (vy_q[2]),
      .o_xmin  (xmin),
      .o_xmax  (xmax),
      .o_ymin  (ymin),
      .o_ymax  (ymax),
      .o_empty (bb_empty)
   );

`ifdef RASTER_BACKFACE_CULL_EN
   area_t area;
   always_comb begin
      area = (area_t'(vx_q[1]) - area_t'(vx_q[0])) * (area_t'(vy_q[2]) - area_t'(vy_q[0]))
           - (area_t'(vy_q[1]) - area_t'(vy_q[0])) * (area_t'(vx_q[2]) - area_t'(vx_q[0]));
      cull = (area <= 32'sd0);
   end
`else
   assign cull = 1'b0;
`endif

   assign p_valid = scan_q && !i_stall;

   always_comb begin
      state_d = state_q;
      vx_d    = vx_q;
      vy_d    = vy_q;
      px_d    = px_q;
      py_d    = py_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (i_tri_valid && ready_q) begin
               vx_d[0] = coord_t'(i_x0);
               vy_d[0] = coord_t'(i_y0);
               vx_d[1] = coord_t'(i_x1);
               vy_d[1] = coord_t'(i_y1);
               vx_d[2] = coord_t'(i_x2);
               vy_d[2] = coord_t'(i_y2);
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (bb_empty || cull) begin
               cnt_d   = '0;
               state_d = DRAIN;
            end else begin
               px_d    = xmin;
               py_d    = ymin;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (p_valid) begin
               if (px_q == xmax) begin
                  if (py_q == ymax) begin
                     cnt_d   = DRAIN_LOAD;
                     state_d = DRAIN;
                  end else begin
                     px_d = xmin;
                     py_d = coord_t'(py_q + 16'sd1);
                  end
               end else begin
                  px_d = coord_t'(px_q + 16'sd1);
               end
            end
         end
         DRAIN: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Outputs are registered from the next state so they align with it.
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      scan_d  = (state_d == SCAN);
      done_d  = (state_d == DRAIN) && (cnt_d == '0);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         vx_q    <= '{default: '0};
         vy_q    <= '{default: '0};
         px_q    <= '0;
         py_q    <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         scan_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         px_q    <= px_d;
         py_q    <= py_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         scan_q  <= scan_d;
         done_q  <= done_d;
      end
   end

   assign o_tri_ready = ready_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_p_valid   = p_valid;
   assign o_p_x       = px_q;
   assign o_p_y       = py_q;
   assign o_x0        = vx_q[0];
   assign o_y0        = vy_q[0];
   assign o_x1        = vx_q[1];
   assign o_y1        = vy_q[1];
   assign o_x2        = vx_q[2];
   assign o_y2        = vy_q[2];

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Scoreboard bench for raster_scan_ctrl: reference pixel lists from plain loops over the clamped box.
module tb_raster_scan_ctrl;

   localparam int W   = 320;
   localparam int H   = 240;
   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        rst, tri_valid, stall;
   logic [15:0] x0, y0, x1, y1, x2, y2;
   logic        tri_ready, p_valid, busy, done;
   logic [15:0] ox0, oy0, ox1, oy1, ox2, oy2, p_x, p_y;

   always #5 clk = ~clk;

   raster_scan_ctrl #(
      .SCREEN_W   (W),
      .SCREEN_H   (H),
      .ENGINE_LAT (LAT)
   ) dut (
      .i_clk (clk), .i_rst (rst), .i_tri_valid (tri_valid), .o_tri_ready (tri_ready),
      .i_x0 (x0), .i_y0 (y0), .i_x1 (x1), .i_y1 (y1), .i_x2 (x2), .i_y2 (y2),
      .o_x0 (ox0), .o_y0 (oy0), .o_x1 (ox1), .o_y1 (oy1), .o_x2 (ox2), .o_y2 (oy2),
      .i_stall (stall), .o_p_x (p_x), .o_p_y (p_y), .o_p_valid (p_valid),
      .o_busy (busy), .o_done (done)
   );

   typedef struct {int x; int y;} pix_t;
   typedef struct {int t_acc; bit empty;} tri_t;

   pix_t exp_q[$];
   tri_t tri_q[$];
   int   cur_v [6];
   int   n_cmp = 0, n_bad = 0;
   int   cyc = 0, done_cnt = 0, pix_tri = 0, last_valid_cyc = 0;
   bit   chk_rst = 0, ready_next = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int sv(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   // Reference: clamp the vertex extents to the screen, then enumerate rows then columns.
   function automatic void model(input int t, input int a0, input int b0, input int a1,
                                 input int b1, input int a2, input int b2);
      int xl, xh, yl, yh, n;
      bit cull;
      tri_t tr;
      xl = a0; if (a1 < xl) xl = a1; if (a2 < xl) xl = a2;
      xh = a0; if (a1 > xh) xh = a1; if (a2 > xh) xh = a2;
      yl = b0; if (b1 < yl) yl = b1; if (b2 < yl) yl = b2;
      yh = b0; if (b1 > yh) yh = b1; if (b2 > yh) yh = b2;
      if (xl < 0) xl = 0;
      if (yl < 0) yl = 0;
      if (xh > W - 1) xh = W - 1;
      if (yh > H - 1) yh = H - 1;
      cull = 1'b0;
`ifdef RASTER_BACKFACE_CULL_EN
      cull = ((a1 - a0) * (b2 - b0) - (b1 - b0) * (a2 - a0)) <= 0;
`endif
      n = 0;
      if (!cull)
         for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++) begin
               exp_q.push_back('{x: x, y: y});
               n++;
            end
      tr.t_acc = t;
      tr.empty = (n == 0);
      tri_q.push_back(tr);
      cur_v = '{a0, b0, a1, b1, a2, b2};
   endfunction

   // Monitor: samples on the falling edge, pops the scoreboard on every presented pixel/done.
   always @(negedge clk) begin
      pix_t p;
      tri_t t;
      cyc++;
      if (!rst) begin
         if (chk_rst) begin
            chk("post_rst_valid", int'(p_valid), 0);
            chk("post_rst_busy", int'(busy), 0);
            chk("post_rst_ready", int'(tri_ready), 1);
            chk("post_rst_px", sv(p_x), 0);
            chk_rst = 0;
         end
         chk("ready_vs_busy", int'(tri_ready), int'(!busy));
         if (ready_next) begin
            chk("ready_after_done", int'(tri_ready), 1);
            ready_next = 0;
         end
         if (tri_q.size() > 0 && cyc == tri_q[0].t_acc + 1) begin
            chk("setup_busy", int'(busy), 1);
            chk("setup_no_pix", int'(p_valid), 0);
         end
         if (tri_q.size() > 0 && !tri_q[0].empty && cyc == tri_q[0].t_acc + 2 && !stall)
            chk("first_pix_lat", int'(p_valid), 1);
         if (stall) begin
            chk("valid_under_stall", int'(p_valid), 0);
            if (pix_tri > 0 && exp_q.size() > 0) begin
               chk("hold_x", sv(p_x), exp_q[0].x);
               chk("hold_y", sv(p_y), exp_q[0].y);
            end
         end
         if (p_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pixel_x", sv(p_x), -1);
            end else begin
               p = exp_q.pop_front();
               chk("pix_x", sv(p_x), p.x);
               chk("pix_y", sv(p_y), p.y);
            end
            pix_tri++;
            last_valid_cyc = cyc;
         end
         if (done) begin
            if (tri_q.size() == 0) begin
               chk("unexpected_done", int'(done), 0);
            end else begin
               t = tri_q.pop_front();
               if (t.empty) chk("done_lat_empty", cyc - t.t_acc, 2);
               else         chk("done_lat", cyc - last_valid_cyc, LAT);
               chk("pix_left", exp_q.size(), 0);
               chk("vtx_x0", sv(ox0), cur_v[0]);
               chk("vtx_y0", sv(oy0), cur_v[1]);
               chk("vtx_x1", sv(ox1), cur_v[2]);
               chk("vtx_y1", sv(oy1), cur_v[3]);
               chk("vtx_x2", sv(ox2), cur_v[4]);
               chk("vtx_y2", sv(oy2), cur_v[5]);
            end
            done_cnt++;
            pix_tri = 0;
            ready_next = 1;
         end
      end
   end

   // mode: 0 no stall, 1 random stall, 2 stall n cycles after k pixels, 3 reset after 5 pixels
   task automatic send(input int a0, input int b0, input int a1, input int b1,
                       input int a2, input int b2, input int mode, input int k,
                       input int n, input int budget);
      int d0, used, w;
      bit acc;
      x0 = 16'(a0); y0 = 16'(b0); x1 = 16'(a1); y1 = 16'(b1); x2 = 16'(a2); y2 = 16'(b2);
      tri_valid = 1'b1;
      acc = 1'b0;
      d0 = done_cnt;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(posedge clk);
         if (tri_ready) begin
            model(cyc, a0, b0, a1, b1, a2, b2);
            acc = 1'b1;
         end
      end
      #1;
      tri_valid = 1'b0;
      // Scramble the inputs so any failure to hold the latched vertices shows up.
      {x0, y0, x1, y1, x2, y2} = {$urandom, $urandom, $urandom};
      if (!acc) begin
         chk("accept_timeout", 0, 1);
         return;
      end
      used = 0;
      w = 0;
      while (done_cnt == d0 && w < budget) begin
         if (mode == 3 && pix_tri >= 5) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            exp_q.delete();
            tri_q.delete();
            pix_tri = 0;
            chk_rst = 1;
            repeat (12) @(posedge clk);
            #1;
            chk("no_done_after_rst", done_cnt, d0);
            return;
         end
         if (mode == 1) stall = ($urandom_range(3) == 0);
         else if (mode == 2 && pix_tri >= k && used < n) begin
            stall = 1'b1;
            used++;
         end else stall = 1'b0;
         @(posedge clk);
         #1;
         w++;
      end
      stall = 1'b0;
      if (done_cnt == d0) chk("done_timeout", 0, 1);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; tri_valid = 1'b0; stall = 1'b0;
      {x0, y0, x1, y1, x2, y2} = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", int'(tri_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(p_valid), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_px", sv(p_x), 0);
      chk("rst_vx0", sv(ox0), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      send(2, 1, 5, 1, 2, 4, 0, 0, 0, 200);
      send(-10, -10, -5, -10, -10, -5, 0, 0, 0, 200);
      send(2, 1, 5, 1, 2, 4, 2, 2, 3, 200);
      send(2, 1, 5, 1, 2, 4, 3, 0, 0, 200);
      send(2, 1, 5, 1, 2, 4, 0, 0, 0, 200);
      send(2, 1, 2, 4, 5, 1, 0, 0, 0, 200);
      send(-3, -2, 330, 0, 0, 250, 0, 0, 0, 80000);
      for (int i = 0; i < 16; i++)
         send(int'($urandom_range(24)) - 8, int'($urandom_range(24)) - 8,
              int'($urandom_range(24)) - 8, int'($urandom_range(24)) - 8,
              int'($urandom_range(24)) - 8, int'($urandom_range(24)) - 8,
              1, 0, 0, 2000);
      repeat (5) @(posedge clk);
      #1;
      chk("final_queue_empty", exp_q.size() + tri_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
